// File: rtl/life_pkg.sv
// Shared constants and types for the life-matrix display path.
package life_pkg;

    localparam int unsigned GRID_W = 64;
    localparam int unsigned ROWS   = 8;
    localparam int unsigned COLS   = 8;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_BLANK,
        SCAN_DRIVE
    } scan_state_t;

    // Column slice for one row of a packed generation; bit r*COLS+c is row r, column c.
    function automatic logic [COLS-1:0] grid_row(input logic [GRID_W-1:0] g,
                                                 input logic [2:0]        row);
        return g[row*COLS +: COLS];
    endfunction

endpackage

// File: rtl/life_frame_buffer.sv
// Double buffer between the evolution register and the scan: pending generation,
// pending flag and the displayed generation, swapped only at frame boundaries.
module life_frame_buffer
    import life_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [GRID_W-1:0] grid,
    input  logic              grid_valid,
    input  logic              swap,
    output logic [GRID_W-1:0] display,
    output logic              frame_ack
);

    logic [GRID_W-1:0] pending_q, pending_d;
    logic [GRID_W-1:0] display_q, display_d;
    logic              flag_q, flag_d;
    logic              frame_ack_q;
    logic              take;

    assign take = swap && flag_q;

    // A grid arriving on the swap edge lands in pending after the old value moves out.
    always_comb begin
        pending_d = pending_q;
        display_d = display_q;
        flag_d    = flag_q;
        if (take) begin
            display_d = pending_q;
            flag_d    = 1'b0;
        end
        if (grid_valid) begin
            pending_d = grid;
            flag_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q   <= '0;
            display_q   <= '0;
            flag_q      <= 1'b0;
            frame_ack_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            display_q   <= display_d;
            flag_q      <= flag_d;
            frame_ack_q <= take;
        end
    end

    assign display   = display_q;
    assign frame_ack = frame_ack_q;

endmodule

// File: rtl/life_matrix_scan.sv
// Row-multiplexed scan of an 8x8 LED matrix with anti-ghosting blanking before
// every row and tear-free generation swaps at the start of each frame.
module life_matrix_scan
    import life_pkg::*;
#(
    parameter int unsigned ROW_DWELL    = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [GRID_W-1:0] grid,
    input  logic              grid_valid,
    output logic [ROWS-1:0]   row_sel,
    output logic [COLS-1:0]   col_data,
    output logic              frame_start,
    output logic              frame_ack
);

    localparam int unsigned CNT_MAX = (ROW_DWELL > BLANK_CYCLES) ? ROW_DWELL : BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(ROW_DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t       state_q;
    logic [2:0]        row_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [GRID_W-1:0] display;
    logic              blank_done;
    logic              row_done;
    logic              swap;

    assign blank_done = (cnt_q == BLANK_LAST);
    assign row_done   = (cnt_q == DWELL_LAST);

    // Edges that enter row-0 blanking: leaving idle, or finishing row 7.
    assign swap = enable && ((state_q == SCAN_IDLE) ||
                             (state_q == SCAN_DRIVE && row_done && row_q == 3'd7));

    life_frame_buffer u_frame_buffer (
        .clk        (clk),
        .reset      (reset),
        .grid       (grid),
        .grid_valid (grid_valid),
        .swap       (swap),
        .display    (display),
        .frame_ack  (frame_ack)
    );

    always_ff @(posedge clk) begin
        if (!reset || !enable) begin
            state_q     <= SCAN_IDLE;
            row_q       <= 3'd0;
            cnt_q       <= '0;
            row_sel     <= '0;
            col_data    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            unique case (state_q)
                SCAN_IDLE: begin
                    state_q     <= SCAN_BLANK;
                    row_q       <= 3'd0;
                    cnt_q       <= '0;
                    row_sel     <= '0;
                    col_data    <= '0;
                    frame_start <= 1'b1;
                end
                SCAN_BLANK: begin
                    if (blank_done) begin
                        state_q  <= SCAN_DRIVE;
                        cnt_q    <= '0;
                        row_sel  <= ROWS'(1) << row_q;
                        col_data <= grid_row(display, row_q);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SCAN_DRIVE: begin
                    if (row_done) begin
                        state_q     <= SCAN_BLANK;
                        cnt_q       <= '0;
                        row_q       <= row_q + 3'd1;
                        row_sel     <= '0;
                        col_data    <= '0;
                        frame_start <= (row_q == 3'd7);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q  <= SCAN_IDLE;
                    row_q    <= 3'd0;
                    cnt_q    <= '0;
                    row_sel  <= '0;
                    col_data <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_matrix_scan.sv
// Scoreboard bench: a frame-position model predicts every registered output cycle.
module tb_life_matrix_scan;

    localparam int unsigned D     = 4;
    localparam int unsigned B     = 2;
    localparam int unsigned PER   = B + D;
    localparam int unsigned FRAME = 8 * PER;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        grid_valid = 1'b0;
    logic [63:0] grid = '0;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_start;
    logic        frame_ack;

    life_matrix_scan #(
        .ROW_DWELL    (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .grid        (grid),
        .grid_valid  (grid_valid),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_start (frame_start),
        .frame_ack   (frame_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] rs;
        logic [7:0] cd;
        logic       fs;
        logic       fa;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Model: time since scan start gives row and phase directly.
    bit          m_scan = 1'b0;
    int          m_t = 0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_disp = '0;
    bit          m_flag = 1'b0;

    task automatic model_edge(input bit rst, input bit en, input logic [63:0] g, input bit gv);
        exp_t e;
        int   ph;
        int   r;
        bit   sw;
        bit   ack;
        e = '0;
        if (!rst) begin
            m_scan = 1'b0;
            m_t    = 0;
            m_pend = '0;
            m_disp = '0;
            m_flag = 1'b0;
        end else begin
            if (!en) begin
                m_scan = 1'b0;
                m_t    = 0;
            end else begin
                if (m_scan) m_t++;
                else begin
                    m_scan = 1'b1;
                    m_t    = 0;
                end
                sw  = (m_t % FRAME) == 0;
                ack = sw && m_flag;
                if (ack) begin
                    m_disp = m_pend;
                    m_flag = 1'b0;
                end
                ph   = m_t % PER;
                r    = (m_t / PER) % 8;
                e.fs = sw;
                e.fa = ack;
                if (ph >= int'(B)) begin
                    e.rs = 8'(1 << r);
                    e.cd = m_disp[r*8 +: 8];
                end
            end
            if (gv) begin
                m_pend = g;
                m_flag = 1'b1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit rst, input bit en, input logic [63:0] g, input bit gv);
        reset      = rst;
        enable     = en;
        grid       = g;
        grid_valid = gv;
        @(posedge clk);
        model_edge(rst, en, g, gv);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 64'h0, 1'b0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                if (row_sel !== mon_e.rs || col_data !== mon_e.cd ||
                    frame_start !== mon_e.fs || frame_ack !== mon_e.fa) begin
                    failures++;
                    $display("FAIL outputs @%0t: got row_sel=%h col_data=%h fs=%b fa=%b, want row_sel=%h col_data=%h fs=%b fa=%b",
                             $time, row_sel, col_data, frame_start, frame_ack,
                             mon_e.rs, mon_e.cd, mon_e.fs, mon_e.fa);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, {$urandom, $urandom}, 1'b1);
        run(2 * FRAME);

        cyc(1'b1, 1'b1, 64'h8000_0000_0000_0001, 1'b1);
        run(2 * FRAME);

        cyc(1'b1, 1'b1, {8{8'hAA}}, 1'b1);
        run(10);
        cyc(1'b1, 1'b1, {8{8'h55}}, 1'b1);
        run(2 * FRAME);

        // grid arrives exactly on the swap edge with nothing pending
        while (((m_t + 1) % FRAME) != 0) cyc(1'b1, 1'b1, 64'h0, 1'b0);
        cyc(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
        run(2 * FRAME);

        while ((m_t % FRAME) != int'(5 * PER + B + 1)) cyc(1'b1, 1'b1, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 64'h0, 1'b0);
        run(FRAME + 10);

        while ((m_t % FRAME) != int'(3 * PER + B + 1)) cyc(1'b1, 1'b1, 64'h0, 1'b0);
        cyc(1'b0, 1'b1, {$urandom, $urandom}, 1'b1);
        run(FRAME + 5);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 199) != 0),
                {$urandom, $urandom}, ($urandom_range(0, 19) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/life_matrix_scan.md
LIFE_MATRIX_SCAN -- requirements
Module: life_matrix_scan

Interface
REQ-001 Parameter ROW_DWELL, default 1000, is the number of cycles each row is driven; legal range is 1 or more.
REQ-002 Parameter BLANK_CYCLES, default 16, is the number of anti-ghosting blank cycles before each row; legal range is 1 or more.
REQ-003 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, is a synchronous, active-low reset.
REQ-005 Port enable, input, 1 bit, runs the scan while high.
REQ-006 Port grid, input, 64 bits, is the generation from the evolution register; bit r*8+c is row r, column c.
REQ-007 Port grid_valid, input, 1 bit, is a one-cycle strobe that a new generation is present on grid.
REQ-008 Port row_sel, output, 8 bits, is the one-hot, active-high row drive.
REQ-009 Port col_data, output, 8 bits, is the column data for the driven row; bit c is column c.
REQ-010 Port frame_start, output, 1 bit, is a one-cycle pulse at the start of row 0 blanking.
REQ-011 Port frame_ack, output, 1 bit, is a one-cycle pulse when the pending generation is moved into the display buffer.

Function
REQ-012 The block SHALL hold a pending buffer, a pending flag and a display buffer, each register-based.
REQ-013 When grid_valid=1, the block SHALL write grid into the pending buffer and set the pending flag; the latest write wins and earlier un-displayed generations are dropped.
REQ-014 The scan FSM SHALL have three states: SCAN_IDLE, SCAN_BLANK and SCAN_DRIVE.
REQ-015 SCAN_IDLE SHALL move to SCAN_BLANK when enable=1, with row=0.
REQ-016 SCAN_BLANK SHALL last exactly BLANK_CYCLES cycles, drive row_sel=0 and col_data=0, then move to SCAN_DRIVE.
REQ-017 SCAN_DRIVE SHALL last exactly ROW_DWELL cycles, drive row_sel=1<<row and col_data=display[row*8+7 : row*8], then set row to (row+1) mod 8 and move to SCAN_BLANK.
REQ-018 The row counter SHALL be 3 bits and wrap from 7 to 0 with no idle gap, giving a frame period of 8*(BLANK_CYCLES+ROW_DWELL) cycles.
REQ-019 On every clock edge that enters SCAN_BLANK with row=0, if the pending flag is set, the block SHALL copy pending into display and assert frame_ack for the first cycle of that blank period.
REQ-020 frame_start SHALL be asserted for the first cycle of every row-0 blank period, whether or not a swap occurs.
REQ-021 If grid_valid coincides with a swap edge, the display buffer SHALL take the old pending value, the pending buffer SHALL take grid, and the pending flag SHALL remain set.
REQ-022 If grid_valid coincides with a swap edge while the pending flag is clear, there SHALL be no bypass; the grid is displayed at the next frame.
REQ-023 The display buffer SHALL never change except at a swap edge, so there is no tearing within a frame.
REQ-024 When enable=0 in any state, the block SHALL enter SCAN_IDLE on the next edge, clear the row and counters, and drive row_sel=0 and col_data=0; the pending and display buffers SHALL be retained.
REQ-025 All outputs SHALL be registered or decoded only from registered state, with no combinational path from inputs to outputs.
REQ-026 The dwell counter SHALL be sized $clog2(max(ROW_DWELL, BLANK_CYCLES)+1) bits and SHALL NOT overflow.

Reset
REQ-027 With reset=0 at a clock edge, the block SHALL enter SCAN_IDLE with row=0, counter=0, pending flag=0, pending=0 and display=0.
REQ-028 During reset, row_sel, col_data, frame_start and frame_ack SHALL all be 0.
REQ-029 A reset mid-frame SHALL abort the scan immediately, with no partial swap and a grid_valid in the reset cycle ignored.

Structure
REQ-030 The shared package life_pkg SHALL hold GRID_W=64, ROWS=8, COLS=8 and the typedef enum scan_state_t {SCAN_IDLE, SCAN_BLANK, SCAN_DRIVE}.
REQ-031 The sub-module life_frame_buffer SHALL hold the pending buffer, pending flag, display buffer and swap logic; the scan FSM and counters SHALL live in the top module.

Verification (ROW_DWELL=4, BLANK_CYCLES=2 unless noted)
REQ-032 Reset, then enable=1: row_sel=0 for 2 cycles, then 0x01 for 4 cycles, then 2 cycles of 0, then 0x02, and so on; frame_start recurs every 48 cycles.
REQ-033 grid=0x8000_0000_0000_0001 with grid_valid pulsed before frame 1: after the swap, col_data=0x01 while row_sel=0x01, col_data=0x80 while row_sel=0x80, and 0x00 on all other rows; frame_ack is pulsed once.
REQ-034 grid_valid pulsed with 0xAA.. and then 0x55.. inside one frame: only 0x55.. is displayed next frame, with a single frame_ack.
REQ-035 grid_valid pulsed in the swap-edge cycle with the pending flag clear: display is unchanged this frame, the new grid is shown next frame, and frame_ack occurs in the next frame only.
REQ-036 enable dropped mid-row 5, then raised 3 cycles later: outputs are 0 while idle, the scan restarts at row 0 blanking, and the display contents are retained.
REQ-037 reset=0 asserted during SCAN_DRIVE of row 3: all outputs are 0 the next cycle, the display buffer is cleared, and after release with enable=1 the scan starts at row 0.
